// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants used by master and slave.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore
    } slave_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line plus a history flop for single-cycle edge events.
module i2c_sync_edge #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              hist_q;

    // Reset to the idle-high bus level so leaving reset never fakes an edge on a quiet bus.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[Stages-2:0], sig_i};
            hist_q <= sync_q[Stages-1];
        end
    end

    assign level_o = sync_q[Stages-1];
    assign rise_o  = sync_q[Stages-1] & ~hist_q;
    assign fall_o  = ~sync_q[Stages-1] & hist_q;

endmodule

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection, byte strobes to local logic.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iSCL,
    inout  wire        ioSDA,
    output logic [7:0] oRx_Data,
    output logic       oRx_Valid,
    input  logic [7:0] iTx_Data,
    output logic       oTx_Req,
    output logic       oTx_Done,
    output logic       oTx_Nack,
    output logic       oAddr_Match,
    output logic       oBusy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    slave_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [6:0]   shift_q, shift_d;
    logic         rw_q, rw_d;
    logic         ack_pending_q, ack_pending_d;
    logic         sda_oe_q, sda_oe_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         tx_req_q, tx_req_d;
    logic         tx_done_q, tx_done_d;
    logic         tx_nack_q, tx_nack_d;
    logic         addr_match_q, addr_match_d;
    logic         busy_q, busy_d;

    i2c_sync_edge #(
        .Stages (SYNC_STAGES)
    ) u_sync_scl (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .sig_i   (iSCL),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(
        .Stages (SYNC_STAGES)
    ) u_sync_sda (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .sig_i   (ioSDA),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 7'd0;
            rw_q          <= 1'b0;
            ack_pending_q <= 1'b0;
            sda_oe_q      <= 1'b0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            tx_req_q      <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_nack_q     <= 1'b0;
            addr_match_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rw_q          <= rw_d;
            ack_pending_q <= ack_pending_d;
            sda_oe_q      <= sda_oe_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_req_q      <= tx_req_d;
            tx_done_q     <= tx_done_d;
            tx_nack_q     <= tx_nack_d;
            addr_match_q  <= addr_match_d;
            busy_q        <= busy_d;
        end
    end

    // START/STOP override every state so a misbehaving transfer can always be abandoned.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = StAddr;
        end else if (stop_det) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: state_d = state_q;
                StAddr: begin
                    if (scl_rise && bit_cnt_q == 3'd7 && shift_q != SLAVE_ADDR) begin
                        state_d = StIgnore;
                    end else if (scl_fall && ack_pending_q) begin
                        state_d = StAddrAck;
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        state_d = (rw_q == I2C_RW_READ) ? StRdData : StWrData;
                    end
                end
                StWrData: begin
                    if (scl_fall && ack_pending_q) begin
                        state_d = StWrAck;
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        state_d = StWrData;
                    end
                end
                StRdData: begin
                    if (scl_fall && bit_cnt_q == 3'd7) begin
                        state_d = StRdAck;
                    end
                end
                StRdAck: begin
                    if (scl_rise && sda_lvl != I2C_ACK) begin
                        state_d = StIgnore;
                    end else if (scl_fall) begin
                        state_d = StRdData;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rw_d          = rw_q;
        ack_pending_d = ack_pending_q;
        sda_oe_d      = sda_oe_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_req_d      = 1'b0;
        tx_done_d     = 1'b0;
        tx_nack_d     = tx_nack_q;
        addr_match_d  = addr_match_q;
        busy_d        = busy_q;
        if (start_det || stop_det) begin
            bit_cnt_d     = 3'd0;
            ack_pending_d = 1'b0;
            sda_oe_d      = 1'b0;
            addr_match_d  = 1'b0;
            busy_d        = start_det;
        end else begin
            unique case (state_q)
                StIdle: sda_oe_d = 1'b0;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7 && shift_q == SLAVE_ADDR) begin
                            rw_d          = sda_lvl;
                            ack_pending_d = 1'b1;
                        end
                    end else if (scl_fall && ack_pending_q) begin
                        ack_pending_d = 1'b0;
                        sda_oe_d      = 1'b1;
                        addr_match_d  = 1'b1;
                    end
                end
                StAddrAck: begin
                    if (scl_rise && rw_q == I2C_RW_READ) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q == I2C_RW_READ) begin
                            // MSB goes straight to the pin; the shifter only holds bits 6..0.
                            shift_d  = iTx_Data[6:0];
                            sda_oe_d = ~iTx_Data[7];
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d     = {shift_q, sda_lvl};
                            rx_valid_d    = 1'b1;
                            ack_pending_d = 1'b1;
                        end
                    end else if (scl_fall && ack_pending_q) begin
                        ack_pending_d = 1'b0;
                        sda_oe_d      = 1'b1;
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                    end
                end
                StRdData: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        tx_done_d = 1'b1;
                        tx_nack_d = (sda_lvl != I2C_ACK);
                        tx_req_d  = (sda_lvl == I2C_ACK);
                    end else if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        shift_d   = iTx_Data[6:0];
                        sda_oe_d  = ~iTx_Data[7];
                    end
                end
                StIgnore: sda_oe_d = 1'b0;
                default:  sda_oe_d = 1'b0;
            endcase
        end
    end

    assign ioSDA       = sda_oe_q ? 1'b0 : 1'bz;
    assign oRx_Data    = rx_data_q;
    assign oRx_Valid   = rx_valid_q;
    assign oTx_Req     = tx_req_q;
    assign oTx_Done    = tx_done_q;
    assign oTx_Nack    = tx_nack_q;
    assign oAddr_Match = addr_match_q;
    assign oBusy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master plus a transaction-level model of the target.
module tb_i2c_slave;

    localparam logic [6:0] SLV = 7'h50;
    localparam int         Q   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, tx_done, tx_nack, addr_match, busy;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda);

    always #5 clk = ~clk;

    i2c_slave #(
        .SLAVE_ADDR  (SLV),
        .SYNC_STAGES (2)
    ) dut (
        .iClk        (clk),
        .iRst_n      (rst_n),
        .iSCL        (scl),
        .ioSDA       (sda),
        .oRx_Data    (rx_data),
        .oRx_Valid   (rx_valid),
        .iTx_Data    (tx_data),
        .oTx_Req     (tx_req),
        .oTx_Done    (tx_done),
        .oTx_Nack    (tx_nack),
        .oAddr_Match (addr_match),
        .oBusy       (busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_req = 0;

    // Model state: what the target must report, fed by the master tasks as transfers are issued.
    logic [7:0] tx_src[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic       exp_nack[$];
    logic       busy_known = 1'b0, busy_exp = 1'b0;
    logic       match_known = 1'b0, match_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rx_valid === 1'b1) begin
            chk("rx_valid_expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
        end
        if (tx_done === 1'b1) begin
            chk("tx_done_expected", exp_nack.size() > 0, 1);
            if (exp_nack.size() > 0) chk("tx_nack", tx_nack, exp_nack.pop_front());
        end
        if (tx_req === 1'b1) begin
            n_req++;
            chk("tx_req_expected", tx_src.size() > 0, 1);
            if (tx_src.size() > 0) tx_data = tx_src.pop_front();
        end
        if (busy_known) chk("busy", busy, busy_exp);
        if (match_known) chk("addr_match", addr_match, match_exp);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mbit(input logic b, output logic r);
        m_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        r = sda;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic m_start();
        if (!busy_exp) busy_known = 1'b0;
        match_known = 1'b0;
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
        busy_exp = 1'b1;
        busy_known = 1'b1;
        match_exp = 1'b0;
        match_known = 1'b1;
    endtask

    task automatic m_stop();
        busy_known = 1'b0;
        match_known = 1'b0;
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b0;
        wait_clk(Q);
        busy_exp = 1'b0;
        busy_known = 1'b1;
        match_exp = 1'b0;
        match_known = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_lvl);
        logic r;
        for (int i = 7; i >= 0; i--) mbit(b[i], r);
        mbit(1'b1, ack_lvl);
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw);
        logic s;
        logic hit;
        hit = (a == SLV);
        m_start();
        match_known = 1'b0;
        send_byte({a, rw}, s);
        chk("addr_ack", s, {31'b0, ~hit});
        match_exp = hit;
        match_known = 1'b1;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic hit);
        logic s;
        if (hit) exp_rx.push_back(b);
        send_byte(b, s);
        chk("data_ack", s, {31'b0, ~hit});
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] got);
        logic r;
        exp_nack.push_back(nack);
        for (int i = 7; i >= 0; i--) begin
            mbit(1'b1, r);
            got[i] = r;
        end
        mbit(nack, r);
        chk("rd_data", got, exp_rd.pop_front());
    endtask

    initial begin
        logic [7:0] g;
        logic r;

        // Reset state.
        wait_clk(3);
        chk("rst_busy", busy, 0);
        chk("rst_match", addr_match, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_nack", tx_nack, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_sda", sda, 1);
        rst_n = 1'b1;
        busy_known = 1'b1;
        match_known = 1'b1;
        wait_clk(4);

        // Write 0xA5, 0x3C to own address.
        addr_phase(SLV, 1'b0);
        wr_byte(8'hA5, 1'b1);
        chk("t1_rx_a5", rx_data, 8'hA5);
        wr_byte(8'h3C, 1'b1);
        chk("t1_rx_3c", rx_data, 8'h3C);
        m_stop();
        chk("t1_sda_free", sda, 1);

        // Foreign address: no ACK, no data strobes.
        addr_phase(7'h51, 1'b0);
        wr_byte(8'h77, 1'b0);
        m_stop();
        chk("t2_rx_kept", rx_data, 8'h3C);

        // Read two bytes, ACK then NACK.
        n_req = 0;
        tx_src.push_back(8'h96); exp_rd.push_back(8'h96);
        tx_src.push_back(8'h0F); exp_rd.push_back(8'h0F);
        addr_phase(SLV, 1'b1);
        rd_byte(1'b0, g);
        chk("t3_byte1", g, 8'h96);
        rd_byte(1'b1, g);
        chk("t3_byte2", g, 8'h0F);
        chk("t3_sda_free", sda, 1);
        m_stop();
        chk("t3_req_count", n_req, 2);

        // Write then repeated START into a read; busy checked every cycle and never dropped.
        addr_phase(SLV, 1'b0);
        wr_byte(8'h11, 1'b1);
        tx_src.push_back(8'hE7); exp_rd.push_back(8'hE7);
        addr_phase(SLV, 1'b1);
        rd_byte(1'b1, g);
        chk("t4_read", g, 8'hE7);
        chk("t4_rx_11", rx_data, 8'h11);
        m_stop();

        // Reset while the target drives a 0 data bit.
        tx_src.push_back(8'h5A);
        addr_phase(SLV, 1'b1);
        chk("t5_drive0", sda, 0);
        busy_known = 1'b0;
        match_known = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_sda_released", sda, 1);
        chk("t5_busy", busy, 0);
        chk("t5_match", addr_match, 0);
        chk("t5_rx_data", rx_data, 0);
        chk("t5_tx_nack", tx_nack, 0);
        wait_clk(1);
        rst_n = 1'b1;
        busy_exp = 1'b0;
        busy_known = 1'b1;
        match_exp = 1'b0;
        match_known = 1'b1;
        m_stop();
        addr_phase(SLV, 1'b0);
        wr_byte(8'hC3, 1'b1);
        m_stop();
        chk("t5_rx_c3", rx_data, 8'hC3);

        // STOP after four data bits: no byte strobe.
        addr_phase(SLV, 1'b0);
        mbit(1'b1, r);
        mbit(1'b0, r);
        mbit(1'b1, r);
        mbit(1'b1, r);
        m_stop();
        wait_clk(4);
        chk("t6_rx_kept", rx_data, 8'hC3);
        chk("t6_sda_free", sda, 1);

        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("nack_queue_drained", exp_nack.size(), 0);
        chk("tx_queue_drained", tx_src.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address I2C target (slave); the responder counterpart of the team's I2C master on the same SCL/SDA pair.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches its own address, receives write bytes and supplies read bytes.
- Exposes byte-level strobes to local logic.
- Open-drain: only ever drives SDA low. No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h50, own 7-bit address.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA, min 2.

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  synchronous active-low reset
- iSCL  in  1  bus clock from master
- ioSDA  inout  1  bus data, driven 0 or released to Z
- oRx_Data  out  8  last received write byte
- oRx_Valid  out  1  1-cycle pulse, oRx_Data updated
- iTx_Data  in  8  next read byte from local logic
- oTx_Req  out  1  1-cycle pulse, local logic must present iTx_Data
- oTx_Done  out  1  1-cycle pulse, read byte's ACK/NACK sampled
- oTx_Nack  out  1  valid with oTx_Done: 1 = master NACKed
- oAddr_Match  out  1  high from address-ACK until STOP/START
- oBusy  out  1  high between START and STOP

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - iRst_n=0 at a posedge iClk: state IDLE, SDA released, all pulses 0, oRx_Data=0, oTx_Nack=0, oAddr_Match=0, oBusy=0, counters 0.
  - Reset mid-transfer releases SDA on the next posedge.
- Front end: SCL and SDA each pass SYNC_STAGES flops plus one history flop.
  - scl_rise / scl_fall / sda_rise / sda_fall are single-cycle events on the synchronized signals.
- START = sda_fall while SCL high. STOP = sda_rise while SCL high. Both take priority over every state.
  - START (including repeated START): goto ADDR, bit_cnt=0, oBusy=1, oAddr_Match=0, SDA released.
  - STOP: goto IDLE, oBusy=0, oAddr_Match=0, SDA released.
- All SDA sampling happens on scl_rise; all SDA drive changes happen on scl_fall. Latency: drive changes 1 clk after scl_fall is seen (SYNC_STAGES+1 clk after the pin edge).
- States:
  - IDLE: wait for START.
  - ADDR: shift SDA in MSB-first on scl_rise, 8 bits (7 address + R/W).
    - On the 8th scl_rise: if addr==SLAVE_ADDR, latch rw and set ack_pending; otherwise goto IGNORE.
    - On the next scl_fall: drive SDA low, oAddr_Match=1, goto ADDR_ACK.
  - ADDR_ACK: SDA held low through the ACK clock.
    - If rw=1: pulse oTx_Req on the ACK scl_rise.
    - On scl_fall: if rw=0, release SDA and goto WR_DATA. If rw=1, load iTx_Data into the shift register, drive SDA=~MSB (low for 0, Z for 1), goto RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise.
    - On the 8th: oRx_Data <= byte, pulse oRx_Valid on the same clk.
    - Next scl_fall: drive ACK low, goto WR_ACK.
  - WR_ACK: on scl_fall, release SDA, bit_cnt=0, goto WR_DATA. Every written byte is ACKed.
  - RD_DATA: on each scl_fall, shift left and drive the next bit.
    - After the 8th bit's scl_fall: release SDA, goto RD_ACK.
  - RD_ACK: on scl_rise, sample SDA; pulse oTx_Done with oTx_Nack=SDA.
    - ACK: pulse oTx_Req on the same clk; on scl_fall load iTx_Data, drive MSB, goto RD_DATA.
    - NACK: goto IGNORE.
  - IGNORE: SDA released; only START/STOP leave.
- iTx_Data is sampled exactly at the scl_fall that ends the ACK bit: at least half an SCL period after oTx_Req.
- bit_cnt is 3 bits and wraps 7->0 at byte end. The address byte is compared on the full 7 bits.
- An SDA change while SCL is high mid-byte is a START/STOP by definition. The data path never sees it.

Decomposition:
- Package i2c_pkg: slave state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE) and the localparams I2C_RW_READ=1 and I2C_ACK=0, shared with the master.
- One sub-module, i2c_sync_edge: synchronizer plus edge detector, instantiated for SCL and SDA.

Test Plan:
- Master write to 0x50, bytes 0xA5, 0x3C, then STOP: slave ACKs the address and both bytes (SDA=0 at the 9th clock). oRx_Valid pulses twice with oRx_Data=0xA5 then 0x3C. oBusy falls after STOP.
- Address 0x51 write: slave never drives SDA, master sees NACK, no oRx_Valid, oAddr_Match stays 0.
- Read from 0x50 with iTx_Data=0x96 then 0x0F; master ACKs byte 1 and NACKs byte 2: bus carries 0x96, 0x0F. oTx_Req pulses twice. oTx_Done pulses twice with oTx_Nack=0 then 1. SDA is released afterwards.
- Write 0x50 byte 0x11, repeated START, read 0x50: ADDR re-entered without STOP, oRx_Data=0x11, read returns iTx_Data, oBusy stays 1 throughout.
- iRst_n=0 while the slave drives a 0 data bit in RD_DATA: SDA goes Z the next clock, all outputs reach reset values, and the next START/0x50 write is ACKed normally.
- STOP issued mid-byte during WR_DATA after 4 bits: goto IDLE, no oRx_Valid, oBusy=0.
